pc_stack_unit: RTL

- Program-counter stage driven by the CPU controller's PC_en / PC_wr / acall strobes. Supplies the ROM fetch address.
- Holds the PC register and a small LIFO return-address stack.
- Implements sequential increment, JMP (load target), ACL (push return address, then load target) and RET (pop into PC).
- Sits directly downstream of the controller and upstream of the ROM address mux (ad_sel path).

---
 rtl/pc_stack_unit_pkg.sv | 24 ++
 rtl/pc_stack_unit_ret_stack.sv | 61 ++++++
 rtl/pc_stack_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_stack_unit_pkg.sv
// Shared CPU definitions: address width, PC-stage op encodings, and the
// jump/call/return opcodes so the controller and the datapath decode alike.
package pc_stack_unit_pkg;

  localparam int ADDR_W_DEF = 13;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_POP  = 2'd3
  } pc_op_e;

  localparam logic [7:0] OPC_AJMP  = 8'h01;
  localparam logic [7:0] OPC_LJMP  = 8'h02;
  localparam logic [7:0] OPC_ACALL = 8'h11;
  localparam logic [7:0] OPC_LCALL = 8'h12;
  localparam logic [7:0] OPC_RET   = 8'h22;

  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_stack_unit_ret_stack.sv
// LIFO return-address stack indexed by sp; pushes when full and pops when empty
// are dropped here. sp/full/empty update on the clock edge of the strobe.
module pc_stack_unit_ret_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:0]        din_i,
  output logic [ADDR_W-1:0]        dout_o,
  output logic [$clog2(DEPTH):0]   sp_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = sp_width(DEPTH);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_idx;
  logic              do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SP_W'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Contents need no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[sp_q[PTR_W-1:0]] <= din_i;
    end
  end

  assign rd_idx = sp_q[PTR_W-1:0] - PTR_W'(1);
  assign dout_o = mem_q[rd_idx];
  assign sp_o   = sp_q;

endmodule

// File: rtl/pc_stack_unit.sv
// PC register with increment / jump / call / return and a return-address stack.
// One-cycle strobe-to-pc_addr latency; no backpressure, over/underflow set sticky flags.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PC_en,
  input  logic                   PC_wr,
  input  logic                   acall,
  input  logic [ADDR_W-1:0]      jmp_addr,
  output logic [ADDR_W-1:0]      pc_addr,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   stk_full,
  output logic                   stk_empty,
  output logic                   stk_ovf,
  output logic                   stk_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stk_top;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  pc_op_e            op_q, op_d;
  logic              is_call, is_jmp, is_ret, is_inc;

  assign is_call = PC_wr && acall;
  assign is_jmp  = PC_wr && !acall;
  assign is_ret  = !PC_wr && acall;
  assign is_inc  = PC_en && !PC_wr && !acall;

  pc_stack_unit_ret_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ret_stack (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (is_call),
    .pop_i   (is_ret),
    .din_i   (pc_q),
    .dout_o  (stk_top),
    .sp_o    (sp),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Return address is the already-advanced PC, so it is pushed unmodified.
  always_comb begin
    pc_d  = pc_q;
    op_d  = OP_IDLE;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (is_call || is_jmp) begin
      pc_d  = jmp_addr;
      op_d  = OP_LOAD;
      ovf_d = ovf_q || (is_call && stk_full);
    end else if (is_ret) begin
      op_d  = OP_POP;
      if (stk_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d = stk_top;
      end
    end else if (is_inc) begin
      pc_d = pc_q + ADDR_W'(1);
      op_d = OP_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RST_PC;
      op_q  <= OP_IDLE;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      op_q  <= op_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_addr = pc_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

  // op_q is a debug record of the last decoded operation.
  a_pop_from_ret : assert property (@(posedge clk) disable iff (!rst)
    (op_q == OP_POP) |-> $past(acall && !PC_wr));

endmodule
